// File: rtl/rv523_cell_pkg.sv
// Shared definitions for the 4-input cell exerciser.
//   cell4_state_t : exerciser FSM states
//   TT_*          : expected-Y truth tables, bit v is the output for vector v
//                   (A1 = v[0] ... A4 = v[3])
package rv523_cell_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_DONE
  } cell4_state_t;

  localparam logic [15:0] TT_NAND4 = 16'h7FFF;
  localparam logic [15:0] TT_NOR4  = 16'h0001;
  localparam logic [15:0] TT_AND4  = 16'h8000;
  localparam logic [15:0] TT_OR4   = 16'hFFFE;

  localparam logic [3:0] VEC_LAST = 4'd15;

endpackage

// File: rtl/cell4_settle_timer.sv
// Settle-time down-counter for the cell exerciser.
//   clk  : clock
//   rst  : synchronous active-high reset
//   load : reload the counter with SETTLE (asserted on the edge entering APPLY)
//   dec  : count down (high while the FSM sits in APPLY)
//   last : this is the final APPLY cycle; the next edge moves to SAMPLE
module cell4_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [3:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= 4'(SETTLE);
    else if (dec && count != 4'd0)
      count <= count - 4'd1;
  end

  // Loaded with SETTLE, decremented once per APPLY cycle: the count reads 1
  // during the SETTLE-th APPLY cycle, so APPLY lasts exactly SETTLE cycles.
  assign last = (count == 4'd1);

endmodule

// File: rtl/cell4_exerciser.sv
// Self-test stimulus/response block for 4-input library cells.
// Walks A1..A4 through all 16 vectors, holds each SETTLE cycles, samples Y
// against TRUTH and reports pass/fail, mismatch count and first failing vector.
//   CLK, RST          : clock, synchronous active-high reset
//   START / ABORT     : run request / run termination (back to IDLE, no DONE)
//   A1..A4            : registered stimulus, A1 = v[0] ... A4 = v[3]
//   Y                 : cell output, same clock domain
//   BUSY, DONE, PASS  : run in progress / run finished (level) / result
//   ERR_CNT           : mismatching vectors, 0..16
//   FAIL_VALID/FAIL_VEC : first failing vector of the run
module cell4_exerciser
  import rv523_cell_pkg::*;
#(
  parameter logic [15:0] TRUTH  = TT_NAND4,
  parameter int          SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       A4,
  input  logic       Y,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_CNT,
  output logic       FAIL_VALID,
  output logic [3:0] FAIL_VEC
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("cell4_exerciser: SETTLE must be in 1..15");
  end

  cell4_state_t state;
  logic [3:0]   v;
  logic [3:0]   drive;
  logic         mismatch;
  logic         enter_apply;
  logic         settle_last;

  assign {A4, A3, A2, A1} = drive;

  // NOTE: case inequality so an X or Z on Y counts as a mismatch instead of
  // silently evaluating to X and skipping the error count.
  assign mismatch = (Y !== TRUTH[v]);

  // NOTE: every always_comb output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    enter_apply = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: enter_apply = START;
      ST_SAMPLE:        enter_apply = !ABORT && (v != VEC_LAST);
      default:          enter_apply = 1'b0;
    endcase
  end

  cell4_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (CLK),
    .rst  (RST),
    .load (enter_apply),
    .dec  (state == ST_APPLY),
    .last (settle_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      v          <= '0;
      drive      <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= '0;
      FAIL_VALID <= 1'b0;
      FAIL_VEC   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state      <= ST_APPLY;
            v          <= '0;
            drive      <= '0;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VALID <= 1'b0;
            FAIL_VEC   <= '0;
          end
        end

        ST_APPLY: begin
          if (ABORT) begin
            state <= ST_IDLE;
            drive <= '0;
            BUSY  <= 1'b0;
          end else if (settle_last) begin
            state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          // Abort wins: the sample of this cycle is dropped, partial results kept.
          if (ABORT) begin
            state <= ST_IDLE;
            drive <= '0;
            BUSY  <= 1'b0;
          end else begin
            if (mismatch) begin
              ERR_CNT <= ERR_CNT + 5'd1;
              if (!FAIL_VALID) begin
                FAIL_VALID <= 1'b1;
                FAIL_VEC   <= v;
              end
            end
            if (v == VEC_LAST) begin
              state <= ST_DONE;
              drive <= '0;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              PASS  <= (ERR_CNT == 5'd0) && !mismatch;
            end else begin
              state <= ST_APPLY;
              v     <= v + 4'd1;
              drive <= v + 4'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell4_exerciser.sv
module tb_cell4_exerciser;
  import rv523_cell_pkg::*;

  localparam int N = 3;  // dut0: SETTLE=2, dut1: SETTLE=1, dut2: SETTLE=15

  typedef enum int {M_NAND, M_FORCE15, M_NOR, M_DLY1, M_DLY2} ymode_t;

  typedef struct {
    int     inst;
    ymode_t mode;
    int     cycles;
    int     err;
    bit     fv;
    int     fvec;
    bit     pass;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [N];
  logic       abt   [N];
  logic       y     [N];
  wire  [3:0] a     [N];
  wire        busy  [N];
  wire        done  [N];
  wire        pass  [N];
  wire  [4:0] err   [N];
  wire        fvalid[N];
  wire  [3:0] fvec  [N];

  ymode_t mode;
  logic   d1[N], d2[N];

  int n_checks = 0;
  int n_pass   = 0;
  row_t exp_q[$];

  always #5 clk = ~clk;

  cell4_exerciser #(.TRUTH(TT_NAND4), .SETTLE(2)) dut0 (
    .CLK(clk), .RST(rst), .START(start[0]), .ABORT(abt[0]),
    .A1(a[0][0]), .A2(a[0][1]), .A3(a[0][2]), .A4(a[0][3]), .Y(y[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(err[0]),
    .FAIL_VALID(fvalid[0]), .FAIL_VEC(fvec[0]));

  cell4_exerciser #(.TRUTH(TT_NAND4), .SETTLE(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start[1]), .ABORT(abt[1]),
    .A1(a[1][0]), .A2(a[1][1]), .A3(a[1][2]), .A4(a[1][3]), .Y(y[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(err[1]),
    .FAIL_VALID(fvalid[1]), .FAIL_VEC(fvec[1]));

  cell4_exerciser #(.TRUTH(TT_NAND4), .SETTLE(15)) dut2 (
    .CLK(clk), .RST(rst), .START(start[2]), .ABORT(abt[2]),
    .A1(a[2][0]), .A2(a[2][1]), .A3(a[2][2]), .A4(a[2][3]), .Y(y[2]),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(err[2]),
    .FAIL_VALID(fvalid[2]), .FAIL_VEC(fvec[2]));

  // Cell models: a NAND4 seen through 1 or 2 register stages of delay.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      d1[i] <= ~&a[i];
      d2[i] <= d1[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      y[i] = ~&a[i];
      case (mode)
        M_FORCE15: y[i] = (a[i] == 4'd15) ? 1'b1 : ~&a[i];
        M_NOR:     y[i] = ~|a[i];
        M_DLY1:    y[i] = d1[i];
        M_DLY2:    y[i] = d2[i];
        default:   y[i] = ~&a[i];
      endcase
    end
  end

  function automatic int settle_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  // Full run: expected result queued at START, popped and compared at DONE.
  // Each cycle of the run the stimulus must follow the vector walk.
  task automatic run_row(input row_t r);
    int   s, j;
    bit   walk_ok;
    row_t e;
    mode = r.mode;
    s    = settle_of(r.inst);
    exp_q.push_back(r);
    pulse_start(r.inst);
    j = 0;
    walk_ok = 1'b1;
    while (done[r.inst] !== 1'b1 && j < 300) begin
      if (a[r.inst] !== 4'(j / (s + 1)) || busy[r.inst] !== 1'b1 ||
          pass[r.inst] !== 1'b0 || done[r.inst] !== 1'b0)
        walk_ok = 1'b0;
      @(posedge clk); #1;
      j++;
    end
    e = exp_q.pop_front();
    check("run_cycles", j, e.cycles);
    check("vector_walk", walk_ok, 1);
    check("a_after_done", a[r.inst], 0);
    check("busy_after_done", busy[r.inst], 0);
    check("pass", pass[r.inst], e.pass);
    check("err_cnt", err[r.inst], e.err);
    check("fail_valid", fvalid[r.inst], e.fv);
    check("fail_vec", fvec[r.inst], e.fvec);
    repeat (3) @(posedge clk);
    #1;
    check("done_held", done[r.inst], 1);
  endtask

  row_t rows[7];

  initial begin
    bit walk_ok;

    // NOR4 vs NAND4 table: vectors 0 and 15 agree, the other 14 differ.
    // 2-cycle-delay cell with SETTLE=1 samples the previous vector's output:
    // NAND4 is 1 for every vector up to 14, so only vector 15 mismatches.
    rows[0] = '{0, M_NAND,    48,  0,  1'b0, 0,  1'b1};
    rows[1] = '{0, M_FORCE15, 48,  1,  1'b1, 15, 1'b0};
    rows[2] = '{0, M_NOR,     48,  14, 1'b1, 1,  1'b0};
    rows[3] = '{1, M_DLY1,    32,  0,  1'b0, 0,  1'b1};
    rows[4] = '{2, M_DLY1,    256, 0,  1'b0, 0,  1'b1};
    rows[5] = '{1, M_DLY2,    32,  1,  1'b1, 15, 1'b0};
    rows[6] = '{0, M_DLY2,    48,  0,  1'b0, 0,  1'b1};

    mode = M_NAND;
    rst  = 1'b1;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      abt[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, START/ABORT held off.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      check("rst_outputs",
            {a[i], busy[i], done[i], pass[i], err[i], fvalid[i], fvec[i]}, 0);
    end

    for (int k = 0; k < 7; k++) run_row(rows[k]);

    // ABORT on the SAMPLE cycle of vector 5 with a NOR4 cell: the vector-5
    // sample is discarded, vectors 1..4 have already counted.
    mode = M_NOR;
    pulse_start(0);
    repeat (17) @(posedge clk);
    #1;
    check("abort_at_vec5", a[0], 5);
    abt[0] = 1'b1;
    @(posedge clk); #1;
    abt[0] = 1'b0;
    check("abort_busy", busy[0], 0);
    check("abort_a", a[0], 0);
    check("abort_done", done[0], 0);
    check("abort_pass", pass[0], 0);
    check("abort_err_kept", err[0], 4);
    check("abort_fv_kept", fvalid[0], 1);
    check("abort_fvec_kept", fvec[0], 1);
    repeat (2) @(posedge clk);
    #1;
    check("abort_stays_idle", {busy[0], done[0]}, 0);
    run_row(rows[0]);

    // START pulses while BUSY must not disturb the walk; RST at vector 9.
    mode = M_NOR;
    pulse_start(0);
    walk_ok = 1'b1;
    for (int j = 0; j < 27; j++) begin
      if (a[0] !== 4'(j / 3) || busy[0] !== 1'b1) walk_ok = 1'b0;
      start[0] = (j == 4 || j == 10);
      @(posedge clk); #1;
    end
    start[0] = 1'b0;
    check("busy_start_ignored", walk_ok, 1);
    check("pre_rst_vec9", a[0], 9);
    check("pre_rst_err", err[0], 8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst_outputs",
          {a[0], busy[0], done[0], pass[0], err[0], fvalid[0], fvec[0]}, 0);
    @(posedge clk); #1;
    check("no_restart_after_rst", busy[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
